stimulus_pulse_gen: RTL



---
 rtl/stimulus_pulse_gen_pkg.sv | 29 ++
 rtl/stimulus_pulse_gen_if.sv | 19 +
 rtl/stimulus_pulse_gen_lfsr.sv | 23 ++
 rtl/stimulus_pulse_gen.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/stimulus_pulse_gen_pkg.sv
// Shared types and constants for the stimulus pulse generator.
// States, register offsets, CTRL/STATUS bit positions, LFSR constants.
package stim_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_PULSE = 2'd2
   } state_t;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_DELAY  = 2'd1;
   localparam logic [1:0] ADDR_WIDTH  = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam int CTRL_START = 0;
   localparam int CTRL_CONT  = 1;
   localparam int CTRL_ABORT = 2;

   localparam int STAT_BUSY = 0;
   localparam int STAT_STIM = 1;
   localparam int STAT_DONE = 2;
   localparam int STAT_RAND = 3;

   // x^16 + x^14 + x^13 + x^11 + 1 -> bits 15,13,12,10
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/stimulus_pulse_gen_if.sv
// Avalon-MM slave bus bundle for the stimulus pulse generator.
// Master drives address/strobes/data, slave returns readdata.
interface stimulus_pulse_gen_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/stimulus_pulse_gen_lfsr.sv
// 16-bit Fibonacci LFSR with enable, used for random extra delay.
// Only instantiated when STIM_RANDOM_EN is defined.
module stim_lfsr
   import stim_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_en,
   output logic [15:0] o_lfsr
);
   logic [15:0] r_lfsr;
   logic        w_fb;

   assign w_fb   = ^(r_lfsr & LFSR_TAPS);
   assign o_lfsr = r_lfsr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_lfsr <= LFSR_SEED;
      else if (i_en)
         r_lfsr <= {r_lfsr[14:0], w_fb};
   end
endmodule

// File: rtl/stimulus_pulse_gen.sv
// Programmable delay/width stimulus pulse generator, Avalon-MM slave.
// Optional random extra delay when STIM_RANDOM_EN is defined.
module stimulus_pulse_gen
   import stim_pkg::*;
#(
   parameter int CNT_W     = 24,
   parameter int DELAY_RST = 0,
   parameter int WIDTH_RST = 1,
   parameter int RAND_BITS = 8
) (
   input  logic clk,
   input  logic reset_n,
   stimulus_pulse_gen_if.slave bus,
   output logic stimulus_out,
   output logic busy
);
   localparam int CW = CNT_W + 1;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic            r_stim, w_stim_nxt;
   logic            w_pulse_end;
   logic            r_cont, r_done;
   logic [CNT_W-1:0] r_delay, r_width;
   logic [31:0]     r_readdata, w_rdata;
   logic [CW-1:0]   w_rand, w_delay_ld, w_width_m1;
   logic            w_rand_flag;
   logic            w_wr, w_start, w_abort;
   logic            w_unused_wd;

   assign w_wr    = bus.chipselect & ~bus.write_n;
   assign w_start = w_wr && bus.address == ADDR_CTRL
                    && bus.writedata[CTRL_START];
   assign w_abort = w_wr && bus.address == ADDR_CTRL
                    && bus.writedata[CTRL_ABORT];
   assign w_unused_wd = ^bus.writedata;

`ifdef STIM_RANDOM_EN
   logic [15:0] w_lfsr;
   logic        w_unused_lfsr;

   stim_lfsr u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .i_en    (1'b1),
      .o_lfsr  (w_lfsr)
   );

   assign w_rand        = CW'(w_lfsr[RAND_BITS-1:0]);
   assign w_rand_flag   = 1'b1;
   assign w_unused_lfsr = ^w_lfsr;
`else
   assign w_rand      = '0;
   assign w_rand_flag = 1'b0;
`endif

   // One extra counter bit so DELAY plus the random term never wraps
   assign w_delay_ld = {1'b0, r_delay} + w_rand;
   assign w_width_m1 = (r_width == '0) ? '0
                       : {1'b0, r_width} - CW'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_stim  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_stim  <= w_stim_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_stim_nxt  = r_stim;
      w_pulse_end = 1'b0;
      if (w_abort) begin
         w_state_nxt = ST_IDLE;
         w_stim_nxt  = 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  w_state_nxt = ST_DELAY;
                  w_cnt_nxt   = w_delay_ld;
               end
            end
            ST_DELAY: begin
               if (r_cnt == '0) begin
                  w_state_nxt = ST_PULSE;
                  w_stim_nxt  = 1'b1;
                  w_cnt_nxt   = w_width_m1;
               end else begin
                  w_cnt_nxt = r_cnt - CW'(1);
               end
            end
            ST_PULSE: begin
               if (r_cnt == '0) begin
                  w_stim_nxt  = 1'b0;
                  w_pulse_end = 1'b1;
                  if (r_cont) begin
                     w_state_nxt = ST_DELAY;
                     w_cnt_nxt   = w_delay_ld;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_cnt_nxt = r_cnt - CW'(1);
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy         = (r_state != ST_IDLE);
      stimulus_out = r_stim;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cont  <= 1'b0;
         r_delay <= CNT_W'(DELAY_RST);
         r_width <= CNT_W'(WIDTH_RST);
      end else if (w_wr) begin
         unique case (1'b1)
            bus.address == ADDR_CTRL:
               r_cont <= bus.writedata[CTRL_CONT];
            bus.address == ADDR_DELAY:
               r_delay <= bus.writedata[CNT_W-1:0];
            bus.address == ADDR_WIDTH:
               r_width <= bus.writedata[CNT_W-1:0];
            default: ;
         endcase
      end
   end

   // Pulse completion beats a same-edge clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_done <= 1'b0;
      else if (w_pulse_end)
         r_done <= 1'b1;
      else if (w_wr && bus.address == ADDR_STATUS)
         r_done <= 1'b0;
   end

   always_comb begin
      w_rdata = '0;
      case (bus.address)
         ADDR_CTRL:   w_rdata[CTRL_CONT] = r_cont;
         ADDR_DELAY:  w_rdata = 32'(r_delay);
         ADDR_WIDTH:  w_rdata = 32'(r_width);
         ADDR_STATUS: begin
            w_rdata[STAT_BUSY] = busy;
            w_rdata[STAT_STIM] = r_stim;
            w_rdata[STAT_DONE] = r_done;
            w_rdata[STAT_RAND] = w_rand_flag;
         end
         default: w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_readdata <= '0;
      else
         r_readdata <= w_rdata;
   end

   assign bus.readdata = r_readdata;
endmodule
